// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the RV32I memory stage (mem_access) and its load
// formatter (load_align): opcode / funct3 encodings, the access FSM state
// type and the canonical NOP instruction.
// ---------------------------------------------------------------------------
package mem_pkg;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // ADDI x0,x0,0
   localparam logic [31:0] NOP = 32'h00000013;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } mem_state_t;

endpackage

// File: rtl/mem_access_load_align.sv
// ---------------------------------------------------------------------------
// load_align
// Purely combinational load formatter: picks the byte/half lane of a read
// word and sign- or zero-extends it according to the load funct3.
// Undefined funct3 values return the whole word.
//
// Ports:
//   rdata   in  32  raw word from memory
//   funct3  in   3  load width / signedness
//   offset  in   2  byte offset within the word (offset[1] selects a half)
//   result  out 32  formatted load value
// ---------------------------------------------------------------------------
module load_align
   import mem_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   output logic [31:0] result
);

   logic [7:0]  lane [4];
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign lane[gi] = rdata[8*gi +: 8];
      end
   endgenerate

   assign byte_sel = lane[offset];
   assign half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

   always_comb begin
      result = rdata;
      case (funct3)
         F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   result = {24'h000000, byte_sel};
         F3_H:    result = {{16{half_sel[15]}}, half_sel};
         F3_HU:   result = {16'h0000, half_sel};
         F3_W:    result = rdata;
         default: result = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// ---------------------------------------------------------------------------
// mem_access
// Memory stage of the 5-stage RV32I pipeline. Issues LOAD/STORE accesses on a
// req/ack data-memory port, stalls the pipeline (freeze_cpu) while an access
// is outstanding, formats load data and registers the writeback result.
// An access that sees no ack within ACK_TIMEOUT cycles is abandoned, sets the
// sticky bus_err flag and writes back 0.
//
// Build option: MEM_MISALIGN_TRAP_EN -- when defined, misaligned half/word
// accesses issue no request, write back the faulting address and pulse the
// extra 'misalign' output alongside wb_inst. When undefined the low address
// bits are ignored for halves/words.
//
// Ports:
//   clk, rst (async, active-low)
//   exe_result, mem_addr, mem_inst      from execute
//   dmem_req/we/addr/be/wdata, dmem_rdata/ack   data-memory port
//   freeze_cpu                          combinational stall
//   mem_result, wb_inst                 registered writeback / forwarding
//   bus_err                             sticky timeout flag
//   misalign (option only)              registered misalignment pulse
// ---------------------------------------------------------------------------
module mem_access
   import mem_pkg::*;
#(
   parameter int unsigned ACK_TIMEOUT = 255,
   parameter logic [31:0] NOP_INST    = NOP
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] exe_result,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_inst,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        freeze_cpu,
   output logic [31:0] mem_result,
   output logic [31:0] wb_inst,
   output logic        bus_err
`ifdef MEM_MISALIGN_TRAP_EN
   ,
   output logic        misalign
`endif
);

   localparam logic [15:0] CNT_LAST = 16'(ACK_TIMEOUT - 1);

   // ---------------- decode ----------------
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [1:0] a;
   logic       is_load;
   logic       is_store;
   logic       is_ldst;
   logic       acc_byte;
   logic       acc_half;
   logic       acc_word;
   logic [1:0] eff_off;
   logic       misaligned;
   logic       unused_bits;

   assign opcode   = mem_inst[6:0];
   assign funct3   = mem_inst[14:12];
   assign a        = mem_addr[1:0];
   assign is_load  = (opcode == OP_LOAD);
   assign is_store = (opcode == OP_STORE);
   assign is_ldst  = is_load | is_store;

   // Stores only know B/H/W; loads additionally have the unsigned variants.
   // Anything else is a full-word access.
   assign acc_byte = is_store ? (funct3 == F3_B) : ((funct3 == F3_B) | (funct3 == F3_BU));
   assign acc_half = is_store ? (funct3 == F3_H) : ((funct3 == F3_H) | (funct3 == F3_HU));
   assign acc_word = ~acc_byte & ~acc_half;

`ifdef MEM_MISALIGN_TRAP_EN
   assign misaligned = is_ldst & ((acc_half & a[0]) | (acc_word & (a != 2'b00)));
   assign eff_off    = a;
`else
   assign misaligned = 1'b0;
   // Low bits below the access size are simply dropped.
   assign eff_off    = acc_byte ? a : (acc_half ? {a[1], 1'b0} : 2'b00);
`endif

   assign unused_bits = ^{mem_inst[31:15], mem_inst[11:7]};

   // ---------------- memory port data path ----------------
   logic [3:0] be_base;

   assign be_base   = acc_byte ? 4'b0001 : (acc_half ? 4'b0011 : 4'b1111);
   assign dmem_be   = is_store ? (be_base << eff_off) : 4'b1111;
   assign dmem_we   = is_store;
   assign dmem_addr = {mem_addr[31:2], 2'b00};

   // Store data is replicated across lanes so the byte enables alone pick
   // the destination bytes.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_wlane
         assign dmem_wdata[8*gi +: 8] = acc_byte ? exe_result[7:0] :
                                        acc_half ? exe_result[8*(gi%2) +: 8] :
                                                   exe_result[8*gi +: 8];
      end
   endgenerate

   logic [31:0] load_data;

   load_align u_load_align (
      .rdata  (dmem_rdata),
      .funct3 (funct3),
      .offset (eff_off),
      .result (load_data)
   );

   // ---------------- access FSM ----------------
   mem_state_t  state_reg, state_next;
   logic [15:0] cnt_reg, cnt_next;
   logic        timeout;

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      dmem_req   = 1'b0;
      freeze_cpu = 1'b0;
      timeout    = 1'b0;
      case (state_reg)
         IDLE: begin
            // Any ack seen here is stale and deliberately ignored.
            if (is_ldst && !misaligned) begin
               dmem_req   = 1'b1;
               freeze_cpu = 1'b1;
               cnt_next   = 16'd0;
               state_next = REQ;
            end
         end
         REQ: begin
            if (dmem_ack) begin
               // Ack takes priority over a timeout landing in the same cycle.
               dmem_req   = 1'b1;
               state_next = IDLE;
            end else if (cnt_reg == CNT_LAST) begin
               timeout    = 1'b1;
               state_next = IDLE;
            end else begin
               dmem_req   = 1'b1;
               freeze_cpu = 1'b1;
               cnt_next   = cnt_reg + 16'd1;
            end
         end
         default: state_next = IDLE;
      endcase
      // Keep the port quiet and the pipeline running while held in reset.
      if (!rst) begin
         dmem_req   = 1'b0;
         freeze_cpu = 1'b0;
         timeout    = 1'b0;
      end
   end

   // ---------------- writeback registers ----------------
   logic [31:0] result_next;
   logic [31:0] mem_result_reg;
   logic [31:0] wb_inst_reg;
   logic        bus_err_reg;

   always_comb begin
      result_next = exe_result;
      if (timeout)
         result_next = 32'h00000000;
      else if (misaligned)
         result_next = mem_addr;
      else if (is_load)
         result_next = load_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg      <= IDLE;
         cnt_reg        <= 16'd0;
         wb_inst_reg    <= NOP_INST;
         mem_result_reg <= 32'h00000000;
         bus_err_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (timeout)
            bus_err_reg <= 1'b1;
         // A frozen stage holds, so writeback repeats the older instruction.
         if (!freeze_cpu) begin
            wb_inst_reg    <= mem_inst;
            mem_result_reg <= result_next;
         end
      end
   end

`ifdef MEM_MISALIGN_TRAP_EN
   logic misalign_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         misalign_reg <= 1'b0;
      else if (!freeze_cpu)
         misalign_reg <= misaligned;
   end

   assign misalign = misalign_reg;
`endif

   assign mem_result = mem_result_reg;
   assign wb_inst    = wb_inst_reg;
   assign bus_err    = bus_err_reg;

endmodule

// File: tb/tb_mem_access.sv
// ---------------------------------------------------------------------------
// tb_mem_access
// Self-checking bench for mem_access: a table of hand-computed vectors, a
// randomized run against an arithmetic reference model, and hand-written
// sequences for timeout, reset during an access and (when built with
// MEM_MISALIGN_TRAP_EN) the misalignment trap.
// ---------------------------------------------------------------------------
module tb_mem_access;
   import mem_pkg::*;

   localparam int T = 4;

   logic        clk;
   logic        rst;
   logic [31:0] exe_result;
   logic [31:0] mem_addr;
   logic [31:0] mem_inst;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;
   logic        freeze_cpu;
   logic [31:0] mem_result;
   logic [31:0] wb_inst;
   logic        bus_err;
`ifdef MEM_MISALIGN_TRAP_EN
   logic        misalign;
`endif

   mem_access #(.ACK_TIMEOUT(T), .NOP_INST(32'h00000013)) dut (
      .clk        (clk),
      .rst        (rst),
      .exe_result (exe_result),
      .mem_addr   (mem_addr),
      .mem_inst   (mem_inst),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .dmem_addr  (dmem_addr),
      .dmem_be    (dmem_be),
      .dmem_wdata (dmem_wdata),
      .dmem_rdata (dmem_rdata),
      .dmem_ack   (dmem_ack),
      .freeze_cpu (freeze_cpu),
      .mem_result (mem_result),
      .wb_inst    (wb_inst),
      .bus_err    (bus_err)
`ifdef MEM_MISALIGN_TRAP_EN
      ,
      .misalign   (misalign)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int n_vec;
   int n_err;
   int n_txn;
   logic exp_bus_err;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] addr;
      logic [31:0] exe;
      logic [31:0] rdata;
      int          delay;
      logic        req;
      int          frz;
      logic [31:0] res;
      logic [3:0]  be;
      logic [31:0] wd;
   } vec_t;

   vec_t vecs [12];

   function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3);
      return {12'h000, 5'd1, f3, 5'd5, op};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: derives the expected outcome of one instruction from
   // the access size, byte offset and ack latency using plain arithmetic.
   task automatic ref_model(input logic [31:0] inst, addr, exe, rdata, input int delay,
                            output logic req, output int frz, output logic [31:0] res,
                            output logic [3:0] be, output logic [31:0] wd, output logic mis);
      logic [2:0] f3;
      logic       ld, st, sgn, tmo;
      int         size, off;
      longint     v, w, be_l;
      f3   = inst[14:12];
      ld   = (inst[6:0] == 7'b0000011);
      st   = (inst[6:0] == 7'b0100011);
      size = 4;
      if (ld) begin
         if (f3 == 3'd0 || f3 == 3'd4) size = 1;
         else if (f3 == 3'd1 || f3 == 3'd5) size = 2;
      end else if (st) begin
         if (f3 == 3'd0) size = 1;
         else if (f3 == 3'd1) size = 2;
      end
      sgn = (f3 == 3'd0) || (f3 == 3'd1);
      off = int'(addr % 4);
      mis = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      mis = (ld || st) && (off % size != 0);
`else
      off = off - (off % size);
`endif
      req = (ld || st) && !mis;
      tmo = req && (delay >= T);
      frz = req ? (1 + (tmo ? T - 1 : delay)) : 0;
      v = (longint'(rdata) >> (8 * off)) % (longint'(1) << (8 * size));
      if (sgn && size < 4 && v >= (longint'(1) << (8 * size - 1)))
         v = v - (longint'(1) << (8 * size));
      if (mis)      res = addr;
      else if (tmo) res = 32'h0;
      else if (ld)  res = v[31:0];
      else          res = exe;
      be_l = st ? (((longint'(1) << size) - 1) << off) : 64'd15;
      be   = be_l[3:0];
      v = longint'(exe) % (longint'(1) << (8 * size));
      w = 0;
      for (int i = 0; i < 4 / size; i++)
         w = w + (v << (8 * size * i));
      wd = w[31:0];
   endtask

   // Applies one instruction (entered and left #1 after a rising edge),
   // acting as the memory: ack arrives 'delay' cycles into REQ.
   task automatic run_txn(input logic [31:0] inst, addr, exe, rdata, input int delay,
                          input logic exp_req, input int exp_frz, input logic [31:0] exp_res,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd, input logic exp_mis);
      int   frz;
      logic st, tmo;
      frz = 0;
      st  = (inst[6:0] == OP_STORE);
      tmo = exp_req && (delay >= T);
      mem_inst   = inst;
      mem_addr   = addr;
      exe_result = exe;
      dmem_rdata = rdata;
      dmem_ack   = 1'b0;
      for (int c = 0; c < 64; c++) begin
         dmem_ack = exp_req && (c == delay + 1);
         @(negedge clk);
         if (c == 0) begin
            chk("req_issue", 32'(dmem_req), 32'(exp_req));
            if (exp_req) begin
               chk("dmem_addr", dmem_addr, {addr[31:2], 2'b00});
               chk("dmem_we", 32'(dmem_we), 32'(st));
               chk("dmem_be", 32'(dmem_be), 32'(exp_be));
               if (st) chk("dmem_wdata", dmem_wdata, exp_wd);
            end
         end
         if (freeze_cpu !== 1'b1) break;
         frz++;
         @(posedge clk);
         #1;
      end
      if (exp_req) chk("req_at_release", 32'(dmem_req), 32'(!tmo));
      chk("freeze_cycles", 32'(frz), 32'(exp_frz));
      if (tmo) exp_bus_err = 1'b1;
      @(posedge clk);
      #1;
      dmem_ack = 1'b0;
      chk("mem_result", mem_result, exp_res);
      chk("wb_inst", wb_inst, inst);
      chk("bus_err", 32'(bus_err), 32'(exp_bus_err));
`ifdef MEM_MISALIGN_TRAP_EN
      chk("misalign", 32'(misalign), 32'(exp_mis));
`endif
      n_txn++;
      $display("txn %0d inst=%h addr=%h exe=%h rdata=%h delay=%0d frz=%0d result=%h mis=%0d",
               n_txn, inst, addr, exe, rdata, delay, frz, mem_result, exp_mis);
   endtask

   initial begin
      logic [31:0] inst, addr, exe, rdata, res, wd;
      logic [3:0]  be;
      logic        req, mis;
      int          frz, delay, kind;
      logic [6:0]  alu_ops [4];

      n_vec = 0;
      n_err = 0;
      n_txn = 0;
      exp_bus_err = 1'b0;
      alu_ops[0] = 7'b0010011;
      alu_ops[1] = 7'b0110011;
      alu_ops[2] = 7'b0110111;
      alu_ops[3] = 7'b1101111;

      //                 inst                    addr          exe           rdata        dly req frz res           be       wd
      vecs[0]  = '{32'h02A00293,           32'h00000000, 32'h0000002A, 32'h00000000, 0, 1'b0, 0, 32'h0000002A, 4'b0000, 32'h0};
      vecs[1]  = '{mk(OP_STORE, F3_B),     32'h00001003, 32'h123456AB, 32'h00000000, 1, 1'b1, 2, 32'h123456AB, 4'b1000, 32'hABABABAB};
      vecs[2]  = '{mk(OP_LOAD, F3_B),      32'h00002001, 32'h00000000, 32'h0000F000, 0, 1'b1, 1, 32'hFFFFFFF0, 4'b1111, 32'h0};
      vecs[3]  = '{mk(OP_LOAD, F3_BU),     32'h00002001, 32'h00000000, 32'h0000F000, 0, 1'b1, 1, 32'h000000F0, 4'b1111, 32'h0};
      vecs[4]  = '{mk(OP_LOAD, F3_HU),     32'h00002002, 32'h00000000, 32'h8001ABCD, 0, 1'b1, 1, 32'h00008001, 4'b1111, 32'h0};
      vecs[5]  = '{mk(OP_LOAD, F3_H),      32'h00002000, 32'h00000000, 32'h8001ABCD, 2, 1'b1, 3, 32'hFFFFABCD, 4'b1111, 32'h0};
      vecs[6]  = '{mk(OP_LOAD, F3_W),      32'h00002004, 32'h00000000, 32'hCAFEF00D, 3, 1'b1, 4, 32'hCAFEF00D, 4'b1111, 32'h0};
      vecs[7]  = '{mk(OP_STORE, F3_H),     32'h00001002, 32'h0000BEEF, 32'h00000000, 0, 1'b1, 1, 32'h0000BEEF, 4'b1100, 32'hBEEFBEEF};
      vecs[8]  = '{mk(OP_STORE, F3_W),     32'h00001004, 32'h11223344, 32'h00000000, 1, 1'b1, 2, 32'h11223344, 4'b1111, 32'h11223344};
      vecs[9]  = '{mk(OP_LOAD, 3'b011),    32'h00002008, 32'h00000000, 32'h87654321, 0, 1'b1, 1, 32'h87654321, 4'b1111, 32'h0};
      vecs[10] = '{mk(OP_STORE, F3_B),     32'h00001000, 32'h0000005A, 32'h00000000, 0, 1'b1, 1, 32'h0000005A, 4'b0001, 32'h5A5A5A5A};
      vecs[11] = '{mk(OP_LOAD, F3_B),      32'h00002003, 32'h00000000, 32'h7F000000, 0, 1'b1, 1, 32'h0000007F, 4'b1111, 32'h0};

      // Reset state, with a load sitting in the stage to prove gating.
      rst        = 1'b0;
      mem_inst   = mk(OP_LOAD, F3_W);
      mem_addr   = 32'h00002000;
      exe_result = 32'h0;
      dmem_rdata = 32'h0;
      dmem_ack   = 1'b0;
      @(negedge clk);
      chk("rst_req", 32'(dmem_req), 32'd0);
      chk("rst_freeze", 32'(freeze_cpu), 32'd0);
      chk("rst_wb_inst", wb_inst, 32'h00000013);
      chk("rst_mem_result", mem_result, 32'h0);
      chk("rst_bus_err", 32'(bus_err), 32'd0);
      @(posedge clk);
      #1;
      mem_inst = 32'h00000013;
      rst      = 1'b1;

      // Table-driven vectors.
      for (int i = 0; i < 12; i++)
         run_txn(vecs[i].inst, vecs[i].addr, vecs[i].exe, vecs[i].rdata, vecs[i].delay,
                 vecs[i].req, vecs[i].frz, vecs[i].res, vecs[i].be, vecs[i].wd, 1'b0);

      // Timeout: no ack ever, stall spans the IDLE cycle plus T-1 REQ cycles.
      run_txn(mk(OP_LOAD, F3_W), 32'h00004000, 32'h00000099, 32'h12345678, 99,
              1'b1, T, 32'h0, 4'b1111, 32'h0, 1'b0);
      // bus_err stays set across a following ordinary instruction.
      run_txn(32'h00100093, 32'h0, 32'h00000001, 32'h0, 0, 1'b0, 0, 32'h00000001, 4'h0, 32'h0, 1'b0);

      // Randomized run against the reference model.
      for (int n = 0; n < 300; n++) begin
         kind  = int'($urandom_range(0, 2));
         inst  = $urandom;
         addr  = $urandom;
         exe   = $urandom;
         rdata = $urandom;
         delay = int'($urandom_range(0, 5));
         if (kind == 0)      inst[6:0] = alu_ops[$urandom_range(0, 3)];
         else if (kind == 1) inst[6:0] = OP_LOAD;
         else begin
            inst[6:0]   = OP_STORE;
            inst[14:12] = 3'($urandom_range(0, 2));
         end
         ref_model(inst, addr, exe, rdata, delay, req, frz, res, be, wd, mis);
         run_txn(inst, addr, exe, rdata, delay, req, frz, res, be, wd, mis);
      end

      // Reset in the middle of an outstanding load; a late ack is ignored.
      mem_inst   = mk(OP_LOAD, F3_W);
      mem_addr   = 32'h00005000;
      exe_result = 32'h0;
      dmem_rdata = 32'hDEADBEEF;
      dmem_ack   = 1'b0;
      @(negedge clk);
      chk("mid_req_issue", 32'(dmem_req), 32'd1);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("mid_freeze", 32'(freeze_cpu), 32'd1);
      #1;
      rst = 1'b0;
      #1;
      exp_bus_err = 1'b0;
      chk("mid_rst_req", 32'(dmem_req), 32'd0);
      chk("mid_rst_freeze", 32'(freeze_cpu), 32'd0);
      chk("mid_rst_wb_inst", wb_inst, 32'h00000013);
      chk("mid_rst_result", mem_result, 32'h0);
      chk("mid_rst_bus_err", 32'(bus_err), 32'd0);
      mem_inst   = 32'h00000013;
      exe_result = 32'h0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      dmem_ack = 1'b1;
      @(negedge clk);
      chk("late_ack_req", 32'(dmem_req), 32'd0);
      chk("late_ack_freeze", 32'(freeze_cpu), 32'd0);
      @(posedge clk);
      #1;
      dmem_ack = 1'b0;
      chk("late_ack_result", mem_result, 32'h0);
      chk("late_ack_wb_inst", wb_inst, 32'h00000013);
      run_txn(mk(OP_LOAD, F3_W), 32'h00006000, 32'h0, 32'h0BADF00D, 0,
              1'b1, 1, 32'h0BADF00D, 4'b1111, 32'h0, 1'b0);

`ifdef MEM_MISALIGN_TRAP_EN
      // Misaligned word: no request, faulting address written back, one-cycle pulse.
      run_txn(mk(OP_LOAD, F3_W), 32'h00003002, 32'h0, 32'h0, 0, 1'b0, 0, 32'h00003002, 4'hF, 32'h0, 1'b1);
      run_txn(32'h00100093, 32'h0, 32'h00000007, 32'h0, 0, 1'b0, 0, 32'h00000007, 4'h0, 32'h0, 1'b0);
`else
      // Low address bits ignored: LW at 0x3002 reads the aligned word.
      run_txn(mk(OP_LOAD, F3_W), 32'h00003002, 32'h0, 32'h13579BDF, 0, 1'b1, 1, 32'h13579BDF, 4'hF, 32'h0, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory stage of the 5-stage RV32I pipeline; sits directly downstream of the execute stage.
- Consumes exe_result, mem_addr and mem_inst from execute.
- Performs LOAD/STORE over a req/ack data-memory port, formats load data and stalls the pipeline via freeze_cpu while an access is outstanding.
- Produces registered mem_result/wb_inst for writeback; mem_result is also the execute stage's forwarding source.

Parameters:
ACK_TIMEOUT, 255, cycles in REQ without dmem_ack before the access is abandoned (1..65535)
NOP_INST, 32'h00000013, instruction injected into wb_inst on reset (ADDI x0,x0,0)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
exe_result  input  32  ALU result / store data from execute
mem_addr  input  32  byte address from execute (0 for non-memory ops)
mem_inst  input  32  instruction currently in memory stage
dmem_req  output  1  access request, held until ack
dmem_we  output  1  1 = store, 0 = load
dmem_addr  output  32  word address: {mem_addr[31:2],2'b00}
dmem_be  output  4  byte enables
dmem_wdata  output  32  lane-replicated store data
dmem_rdata  input  32  read word, valid with dmem_ack
dmem_ack  input  1  one-cycle completion strobe
freeze_cpu  output  1  stall upstream stages (combinational)
mem_result  output  32  registered result for writeback/forwarding
wb_inst  output  32  registered instruction for writeback
bus_err  output  1  sticky: an access timed out

Behaviour:
- Decode uses mem_inst[6:0]. LOAD = 0000011, STORE = 0100011; is_ldst = either.
- FSM states: IDLE, REQ.
  - IDLE, !is_ldst: freeze_cpu=0, dmem_req=0.
  - IDLE, is_ldst: dmem_req=1, freeze_cpu=1; next state REQ, timeout counter cleared.
  - dmem_ack in IDLE is ignored; the memory acks no earlier than one cycle after req rises.
  - REQ: dmem_req=1 and address/we/be/wdata held stable.
    - No ack: freeze_cpu=1 and counter increments.
    - Ack cycle: freeze_cpu=0, result captured at that edge, next state IDLE.
  - Timeout: counter reaching ACK_TIMEOUT-1 without ack ends the access. That cycle: freeze_cpu=0, dmem_req=0, bus_err set, mem_result loaded with 0, state IDLE.
- Store byte enables, by funct3 (inst[14:12]) with a = mem_addr[1:0]:
  - SB: be = 1<<a; wdata = {4{rs2[7:0]}}.
  - SH: be = 0011 << a; wdata = {2{rs2[15:0]}}.
  - SW: be = 1111; wdata = rs2.
  - rs2 = exe_result.
- Loads: be = 1111. Lane selected by a, then:
  - LB: sign-extend the byte.
  - LBU: zero-extend the byte.
  - LH: sign-extend the half (a[1] selects it).
  - LHU: zero-extend the half.
  - LW: full word.
  - Undefined funct3: treated as LW.
- Writeback register update, every edge with freeze_cpu=0:
  - wb_inst <= mem_inst.
  - mem_result <= formatted load data (loads), exe_result (all other ops, stores included).
- With freeze_cpu=1, wb_inst and mem_result hold. Writeback repeats the older instruction idempotently.
- Reset (rst=0), asynchronous: state IDLE, counter 0, wb_inst=NOP_INST, mem_result=0, bus_err=0.
  - dmem_req=0 and freeze_cpu=0 combinationally while in reset.
  - Reset mid-REQ abandons the access; a late ack after release is ignored (state IDLE).
- bus_err clears only on reset.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - Misaligned LH/LHU/SH (a[0]=1) and LW/SW (a!=0) issue no memory request and take no stall.
  - mem_result <= mem_addr (faulting address).
  - Extra output misalign 1-bit, registered, pulsed one cycle with wb_inst.
- Undefined: low address bits are ignored for halves/words (a[0] / a forced to 0); no misalign port.

Decomposition:
- Package mem_pkg: opcode constants (OP_LOAD, OP_STORE), funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), state enum mem_state_t {IDLE, REQ}, NOP constant.
- One sub-module: load_align (combinational rdata/funct3/offset -> formatted 32-bit result), reusable by a future cache.

Test Plan:
1. ADDI x5 in stage, exe_result=0x0000002A, no ack activity -> dmem_req=0, freeze_cpu=0; next edge mem_result=0x2A, wb_inst=ADDI.
2. SB, mem_addr=0x1003, exe_result=0x123456AB, ack 2 cycles after req -> dmem_addr=0x1000, be=1000, wdata=0xABABABAB, freeze_cpu=1 for 2 cycles, 0 on ack cycle.
3. LB, addr=0x2001, rdata=0x0000F000 acked after 1 cycle -> mem_result=0xFFFFFFF0; LBU same -> 0x000000F0; LHU addr=0x2002, rdata=0x8001ABCD -> 0x00008001.
4. LW, ACK_TIMEOUT=4, ack never arrives -> freeze_cpu high 4 cycles then low; bus_err=1; mem_result=0.
5. rst pulled low during REQ of a LW, ack presented 1 cycle after release -> wb_inst=0x00000013, mem_result=0, ack ignored, dmem_req=0.
6. (MEM_MISALIGN_TRAP_EN) LW addr=0x3002 -> no dmem_req, misaligned pulse next edge, mem_result=0x3002.
